// File: rtl/inv_diffusion_if.sv
// rtl/inv_diffusion_if.sv - input/output handshake bundle for inv_diffusion
// States are [row][col] arrays of bytes; master = producer/consumer side, slave = block side.
interface inv_diffusion_if;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0][3:0][7:0]   inv_diffusion_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0][3:0][7:0]   inv_diffusion_out;

    modport master (
        output in_valid,
        output inv_diffusion_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  inv_diffusion_out
    );

    modport slave (
        input  in_valid,
        input  inv_diffusion_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output inv_diffusion_out
    );
endinterface

// File: rtl/inv_diffusion.sv
// rtl/inv_diffusion.sv - sequential AES InvMixColumns + InvShiftRows, one column per clock
// Define INV_DIFFUSION_PARALLEL_EN to process all four columns in a single cycle.
module inv_diffusion (
    input  logic           clk,
    input  logic           reset,
    inv_diffusion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COL, DONE} state_e;
    typedef logic [3:0][3:0][7:0] state_t;

    state_e state_q, state_d;
    state_t in_buf_q, in_buf_d;
    state_t res_q, res_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant whose set bits select the xtime chain terms.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [3:0][7:0] inv_mix_col(input logic [3:0][7:0] s);
        logic [3:0][7:0] m;
        m[0] = gmul(s[0], 4'he) ^ gmul(s[1], 4'hb) ^ gmul(s[2], 4'hd) ^ gmul(s[3], 4'h9);
        m[1] = gmul(s[0], 4'h9) ^ gmul(s[1], 4'he) ^ gmul(s[2], 4'hb) ^ gmul(s[3], 4'hd);
        m[2] = gmul(s[0], 4'hd) ^ gmul(s[1], 4'h9) ^ gmul(s[2], 4'he) ^ gmul(s[3], 4'hb);
        m[3] = gmul(s[0], 4'hb) ^ gmul(s[1], 4'hd) ^ gmul(s[2], 4'h9) ^ gmul(s[3], 4'he);
        return m;
    endfunction

    function automatic logic [3:0][7:0] column(input state_t st, input logic [1:0] c);
        logic [3:0][7:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i] = st[i][c];
        end
        return v;
    endfunction

`ifdef INV_DIFFUSION_PARALLEL_EN
    logic [3:0][3:0][7:0] par_out;

    for (genvar gc = 0; gc < 4; gc++) begin : g_engine
        assign par_out[gc] = inv_mix_col(column(in_buf_q, 2'(gc)));
    end
`else
    logic [1:0]      col_q, col_d;
    logic [3:0][7:0] col_out;

    assign col_out = inv_mix_col(column(in_buf_q, col_q));
`endif

    always_comb begin
        state_d  = state_q;
        in_buf_d = in_buf_q;
        res_d    = res_q;
`ifndef INV_DIFFUSION_PARALLEL_EN
        col_d    = col_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_buf_d = bus.inv_diffusion_in;
                    state_d  = COL;
`ifndef INV_DIFFUSION_PARALLEL_EN
                    col_d    = 2'd0;
`endif
                end
            end
            COL: begin
`ifdef INV_DIFFUSION_PARALLEL_EN
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        res_d[r][c] = par_out[c][r];
                    end
                end
                state_d = DONE;
`else
                for (int r = 0; r < 4; r++) begin
                    res_d[r][col_q] = col_out[r];
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            in_buf_q <= '0;
            res_q    <= '0;
`ifndef INV_DIFFUSION_PARALLEL_EN
            col_q    <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            in_buf_q <= in_buf_d;
            res_q    <= res_d;
`ifndef INV_DIFFUSION_PARALLEL_EN
            col_q    <= col_d;
`endif
        end
    end

    // Handshake outputs are masked during reset so reset wins over any transfer.
    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE) && !reset;

    for (genvar gr = 0; gr < 4; gr++) begin : g_row
        for (genvar gk = 0; gk < 4; gk++) begin : g_col
            assign bus.inv_diffusion_out[gr][gk] = res_q[gr][(gk - gr + 4) % 4];
        end
    end
endmodule
